// File: rtl/bcd_lap_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_lap_timer
//  Purpose  : MM..M:SS BCD up/down timer with a tick prescaler, lower/upper
//             limits, saturating minute adjust and a lap-capture FIFO.
//  Ports    : clk       - rising-edge clock
//             RESET     - synchronous, active-low reset
//             START     - level run enable
//             REVERSE   - 0 = count up toward UPPER, 1 = count down to LOWER
//             CLEAR     - pulse: load direction preset, empty lap FIFO
//             ADD       - pulse: +1 minute, saturates at UPPER
//             SUBTRACT  - pulse: -1 minute, saturates at LOWER
//             LAP       - pulse: push current Q into the lap FIFO
//             LAP_POP   - pulse: drop the lap FIFO head
//             Q         - BCD time, sec units in Q[3:0], minute digits above
//             RUNNING   - START and not at the terminal value
//             DONE      - one-cycle pulse after a tick lands on the terminal
//             LAP_Q     - registered FIFO head (valid with LAP_VALID)
//             LAP_VALID - FIFO not empty
//             LAP_FULL  - FIFO holds LAP_DEPTH entries
//             LAP_OVF   - sticky: a lap was dropped
//             LAP_CNT   - FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_lap_timer #(
    parameter int                        MIN_DIGITS = 2,
    parameter int                        TICK_DIV   = 10,
    parameter logic [8+4*MIN_DIGITS-1:0] LOWER      = '0,
    parameter logic [8+4*MIN_DIGITS-1:0] UPPER      = {{MIN_DIGITS{4'h9}}, 8'h59},
    parameter int                        LAP_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            RESET,
    input  logic                            START,
    input  logic                            REVERSE,
    input  logic                            CLEAR,
    input  logic                            ADD,
    input  logic                            SUBTRACT,
    input  logic                            LAP,
    input  logic                            LAP_POP,
    output logic [8+4*MIN_DIGITS-1:0]       Q,
    output logic                            RUNNING,
    output logic                            DONE,
    output logic [8+4*MIN_DIGITS-1:0]       LAP_Q,
    output logic                            LAP_VALID,
    output logic                            LAP_FULL,
    output logic                            LAP_OVF,
    output logic [$clog2(LAP_DEPTH):0]      LAP_CNT
);

    localparam int W    = 8 + 4*MIN_DIGITS;
    localparam int NDIG = 2 + MIN_DIGITS;
    localparam int AW   = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(LAP_DEPTH);

    // One BCD digit step with carry/borrow in; returns {carry_out, digit}.
    // lim is the digit's maximum (5 for seconds tens, 9 elsewhere).
    function automatic logic [4:0] digit_step(input logic [3:0] d,
                                              input logic [3:0] lim,
                                              input logic       down,
                                              input logic       cin);
        logic [3:0] r;
        logic       c;
        r = d;
        c = 1'b0;
        if (cin) begin
            if (!down) begin
                if (d == lim) begin
                    r = 4'd0;
                    c = 1'b1;
                end else begin
                    r = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    r = lim;
                    c = 1'b1;
                end else begin
                    r = d - 4'd1;
                end
            end
        end
        return {c, r};
    endfunction

    // Ripple a +/-1 starting at digit 'first'; returns {carry_out, value}.
    // first=0 gives a one-second step, first=2 gives a one-minute step.
    function automatic logic [W:0] bcd_ripple(input logic [W-1:0] v,
                                              input logic         down,
                                              input int           first);
        logic [W-1:0] r;
        logic         c;
        logic [4:0]   s;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (i >= first) begin
                s = digit_step(v[4*i +: 4], (i == 1) ? 4'd5 : 4'd9, down, c);
                r[4*i +: 4] = s[3:0];
                c = s[4];
            end
        end
        return {c, r};
    endfunction

    logic [W-1:0]    q;
    logic [PW-1:0]   presc;
    logic            hit;
    logic            done_r;
    logic [W-1:0]    mem [LAP_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     cnt;
    logic            ovf;
    logic [W-1:0]    lap_q;

    logic            terminal;
    logic            running;
    logic            tick;
    logic            adjust;
    logic            tick_applied;
    logic [W:0]      step_raw;
    logic [W:0]      add_raw;
    logic [W:0]      sub_raw;
    logic [W-1:0]    add_val;
    logic [W-1:0]    sub_val;
    logic            step_term;
    logic [W-1:0]    q_next;
    logic [PW-1:0]   presc_next;

    logic            pop_ok;
    logic            push_ok;
    logic            drop;
    logic [AW:0]     cnt_after_pop;
    logic [AW:0]     cnt_next;
    logic [AW-1:0]   rd_next;
    logic [W-1:0]    head_next;

    // Counting datapath
    always_comb begin
        terminal     = REVERSE ? (q == LOWER) : (q == UPPER);
        running      = START && !terminal;
        tick         = running && (presc == PRESC_LAST);
        adjust       = ADD || SUBTRACT;
        // A tick that collides with CLEAR or any adjust request is lost.
        tick_applied = tick && !CLEAR && !adjust;

        step_raw  = bcd_ripple(q, REVERSE, 0);
        step_term = REVERSE ? (step_raw[W-1:0] == LOWER) : (step_raw[W-1:0] == UPPER);

        // Valid BCD orders the same as binary, so limits compare directly.
        // A carry/borrow out of the top minute digit means wrap: saturate.
        add_raw = bcd_ripple(q, 1'b0, 2);
        sub_raw = bcd_ripple(q, 1'b1, 2);
        add_val = (add_raw[W] || (add_raw[W-1:0] > UPPER)) ? UPPER : add_raw[W-1:0];
        sub_val = (sub_raw[W] || (sub_raw[W-1:0] < LOWER)) ? LOWER : sub_raw[W-1:0];

        q_next = q;
        if (CLEAR) begin
            q_next = REVERSE ? UPPER : LOWER;
        end else if (ADD && !SUBTRACT) begin
            q_next = add_val;
        end else if (SUBTRACT && !ADD) begin
            q_next = sub_val;
        end else if (tick_applied) begin
            q_next = step_raw[W-1:0];
        end

        presc_next = '0;
        if (!CLEAR && running && !tick) begin
            presc_next = presc + PW'(1);
        end
    end

    // Lap FIFO control
    always_comb begin
        pop_ok        = LAP_POP && (cnt != '0);
        // A push into a full FIFO is accepted only when a pop frees the slot.
        push_ok       = LAP && ((cnt != DEPTH_CNT) || pop_ok);
        drop          = LAP && !push_ok;
        cnt_after_pop = cnt - (AW+1)'(pop_ok);
        cnt_next      = cnt_after_pop + (AW+1)'(push_ok);
        rd_next       = rd_ptr + AW'(pop_ok);

        // Head register follows the entry that will be at the head next
        // cycle; a push into an (effectively) empty FIFO becomes the head.
        if (cnt_next == '0) begin
            head_next = '0;
        end else if (push_ok && (cnt_after_pop == '0)) begin
            head_next = q;
        end else begin
            head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET) begin
            q      <= LOWER;
            presc  <= '0;
            hit    <= 1'b0;
            done_r <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            lap_q  <= '0;
        end else begin
            q      <= q_next;
            presc  <= presc_next;
            // DONE trails the tick that reached the terminal by one cycle.
            hit    <= tick_applied && step_term;
            done_r <= hit;
            if (CLEAR) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
                ovf    <= 1'b0;
                lap_q  <= '0;
            end else begin
                rd_ptr <= rd_next;
                wr_ptr <= wr_ptr + AW'(push_ok);
                cnt    <= cnt_next;
                lap_q  <= head_next;
                if (drop) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // Storage array needs no reset; occupancy tracking decides validity.
    always_ff @(posedge clk) begin
        if (RESET && !CLEAR && push_ok) begin
            mem[wr_ptr] <= q;
        end
    end

    assign Q         = q;
    assign RUNNING   = running;
    assign DONE      = done_r;
    assign LAP_Q     = lap_q;
    assign LAP_VALID = (cnt != '0);
    assign LAP_FULL  = (cnt == DEPTH_CNT);
    assign LAP_OVF   = ovf;
    assign LAP_CNT   = cnt;

endmodule
`default_nettype wire

// File: tb/tb_bcd_lap_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_lap_timer
//  Purpose  : Self-checking bench for bcd_lap_timer (2 minute digits,
//             TICK_DIV=4, LAP_DEPTH=4). The reference model keeps time as
//             an integer number of seconds and the lap FIFO as a queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_lap_timer;

    localparam int TICK  = 4;
    localparam int DEPTH = 4;
    localparam int LO_S  = 0;
    localparam int UP_S  = 99*60 + 59;

    logic        clk;
    logic        RESET, START, REVERSE, CLEAR, ADD, SUBTRACT, LAP, LAP_POP;
    logic [15:0] Q;
    logic        RUNNING, DONE;
    logic [15:0] LAP_Q;
    logic        LAP_VALID, LAP_FULL, LAP_OVF;
    logic [2:0]  LAP_CNT;

    bcd_lap_timer #(
        .MIN_DIGITS (2),
        .TICK_DIV   (TICK),
        .LOWER      (16'h0000),
        .UPPER      (16'h9959),
        .LAP_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .START     (START),
        .REVERSE   (REVERSE),
        .CLEAR     (CLEAR),
        .ADD       (ADD),
        .SUBTRACT  (SUBTRACT),
        .LAP       (LAP),
        .LAP_POP   (LAP_POP),
        .Q         (Q),
        .RUNNING   (RUNNING),
        .DONE      (DONE),
        .LAP_Q     (LAP_Q),
        .LAP_VALID (LAP_VALID),
        .LAP_FULL  (LAP_FULL),
        .LAP_OVF   (LAP_OVF),
        .LAP_CNT   (LAP_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int          m_sec;
    int          m_pre;
    bit          m_hit;
    bit          m_done;
    bit          m_ovf;
    logic [15:0] fifo[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m, x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic bit at_term(input int s, input logic rev);
        return rev ? (s == LO_S) : (s == UP_S);
    endfunction

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_step();
        bit run, tick;
        if (!RESET) begin
            m_sec  = LO_S;
            m_pre  = 0;
            m_hit  = 0;
            m_done = 0;
            m_ovf  = 0;
            fifo.delete();
            return;
        end
        run    = START && !at_term(m_sec, REVERSE);
        tick   = run && (m_pre == TICK - 1);
        m_done = m_hit;
        m_hit  = 0;

        if (CLEAR) begin
            fifo.delete();
            m_ovf = 0;
        end else begin
            if (LAP_POP && fifo.size() > 0) void'(fifo.pop_front());
            if (LAP) begin
                if (fifo.size() < DEPTH) fifo.push_back(to_bcd(m_sec));
                else m_ovf = 1;
            end
        end

        m_pre = (!CLEAR && run && !tick) ? m_pre + 1 : 0;

        if (CLEAR) begin
            m_sec = REVERSE ? UP_S : LO_S;
        end else if (ADD || SUBTRACT) begin
            if (ADD && !SUBTRACT) m_sec = (m_sec + 60 > UP_S) ? UP_S : m_sec + 60;
            if (SUBTRACT && !ADD) m_sec = (m_sec - 60 < LO_S) ? LO_S : m_sec - 60;
        end else if (tick) begin
            m_sec = REVERSE ? m_sec - 1 : m_sec + 1;
            m_hit = at_term(m_sec, REVERSE);
        end
    endtask

    task automatic compare_all();
        check("Q",         32'(Q),         32'(to_bcd(m_sec)));
        check("RUNNING",   32'(RUNNING),   32'(START && !at_term(m_sec, REVERSE)));
        check("DONE",      32'(DONE),      32'(m_done));
        check("LAP_CNT",   32'(LAP_CNT),   32'(fifo.size()));
        check("LAP_VALID", 32'(LAP_VALID), 32'(fifo.size() != 0));
        check("LAP_FULL",  32'(LAP_FULL),  32'(fifo.size() == DEPTH));
        check("LAP_OVF",   32'(LAP_OVF),   32'(m_ovf));
        if (fifo.size() > 0) check("LAP_Q", 32'(LAP_Q), 32'(fifo[0]));
    endtask

    task automatic cycle(input logic rn, input logic st, input logic rv, input logic cl,
                         input logic ad, input logic sb, input logic lp, input logic pp);
        RESET    = rn;
        START    = st;
        REVERSE  = rv;
        CLEAR    = cl;
        ADD      = ad;
        SUBTRACT = sb;
        LAP      = lp;
        LAP_POP  = pp;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        int  last;
        bit  lp, rv;
        m_sec = 0; m_pre = 0; m_hit = 0; m_done = 0; m_ovf = 0;
        RESET = 0; START = 0; REVERSE = 0; CLEAR = 0;
        ADD = 0; SUBTRACT = 0; LAP = 0; LAP_POP = 0;

        // Reset state
        cycle(0, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 1, 0);
        check("rst_Q",     32'(Q),     32'h0);
        check("rst_LAP_Q", 32'(LAP_Q), 32'h0);

        // Count up from a cleared timer: 0009 at 36, 0010 at 40, 0100 at 240
        cycle(1, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 240; i++) begin
            cycle(1, 1, 0, 0, 0, 0, 0, 0);
            if (i == 36)  check("up_36",  32'(Q), 32'h0009);
            if (i == 40)  check("up_40",  32'(Q), 32'h0010);
            if (i == 240) check("up_240", 32'(Q), 32'h0100);
        end

        // Reverse mid-run down to the lower limit; DONE pulse then hold
        repeat (250) cycle(1, 1, 1, 0, 0, 0, 0, 0);
        check("down_hold", 32'(Q), 32'h0000);

        // Down preset, minute adjusts, then up-count into the upper limit
        cycle(1, 0, 1, 1, 0, 0, 0, 0);
        check("clr_rev", 32'(Q), 32'h9959);
        cycle(1, 0, 1, 0, 1, 1, 0, 0);
        check("add_sub", 32'(Q), 32'h9959);
        cycle(1, 0, 1, 0, 0, 1, 0, 0);
        repeat (250) cycle(1, 1, 0, 0, 0, 0, 0, 0);
        check("up_term", 32'(Q), 32'h9959);

        // Five laps at 0001..0005 into a 4-deep FIFO, then drain it
        cycle(1, 0, 0, 1, 0, 0, 0, 0);
        last = 0;
        for (int i = 0; i < 30; i++) begin
            lp = (m_sec != last) && (m_sec >= 1) && (m_sec <= 5);
            if (lp) last = m_sec;
            cycle(1, 1, 0, 0, 0, 0, lp, 0);
        end
        check("lap_ovf",  32'(LAP_OVF),  32'h1);
        check("lap_full", 32'(LAP_FULL), 32'h1);
        check("lap_head", 32'(LAP_Q),    32'h0001);
        repeat (5) cycle(1, 0, 0, 0, 0, 0, 0, 1);
        check("lap_drained", 32'(LAP_VALID), 32'h0);

        // Randomised operation against the model
        rv = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(63) == 0) rv = !rv;
            cycle(($urandom_range(299) != 0),
                  ($urandom_range(7) != 0),
                  rv,
                  ($urandom_range(99) == 0),
                  ($urandom_range(19) == 0),
                  ($urandom_range(19) == 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
